// File: rtl/display_share_arbiter.sv
// Round-robin time-share of one 4-digit display among n_req sources, with minimum dwell per owner.
// Optional DISPLAY_SHARE_OWNER_DIGIT_EN shows the owner index in the leftmost digit.
module display_share_arbiter #(
    parameter int          n_req        = 4,
    parameter int          dwell_cycles = 25_000_000,
    parameter logic [15:0] idle_number  = 16'h0000
) (
    input  logic                       clk,
    input  logic                       reset_p,
    input  logic [n_req-1:0]           req,
    input  logic [16*n_req-1:0]        number_in,
    output logic [n_req-1:0]           grant,
    output logic [n_req-1:0]           ack,
    output logic [$clog2(n_req)-1:0]   owner,
    output logic                       busy,
    output logic [15:0]                display_number
);
    localparam int OW = $clog2(n_req);
    localparam int CW = $clog2(dwell_cycles);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(dwell_cycles - 1);

    typedef enum logic {ST_IDLE, ST_SHOW} state_t;

    state_t            state_q, state_d;
    logic [n_req-1:0]  grant_q, grant_d;
    logic [n_req-1:0]  ack_q, ack_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [15:0]       display_q, display_d;

    logic [15:0]       src_num [n_req];
    logic [OW-1:0]     win_idx;
    logic [OW-1:0]     cand;
    logic              win_found;

    for (genvar gi = 0; gi < n_req; gi++) begin : g_src
        assign src_num[gi] = number_in[16*gi +: 16];
    end

    // First requester found scanning from last+1, wrapping modulo n_req.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= n_req; k++) begin
            cand = OW'((int'(last_q) + k) % n_req);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ack_d     = '0;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        display_d = idle_number;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (win_found) begin
                    state_d          = ST_SHOW;
                    owner_d          = win_idx;
                    last_d           = win_idx;
                    grant_d[win_idx] = 1'b1;
                    cnt_d            = DWELL_LOAD;
                end
            end
            ST_SHOW: begin
                if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (|(req & ~grant_q)) begin
                    // Dwell served and someone else is waiting: hand over with no idle gap.
                    owner_d          = win_idx;
                    last_d           = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    ack_d            = grant_q;
                    cnt_d            = DWELL_LOAD;
                end else begin
                    cnt_d = DWELL_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = |grant_d;
        if (state_d == ST_SHOW) begin
`ifdef DISPLAY_SHARE_OWNER_DIGIT_EN
            display_d = {{(4-OW){1'b0}}, owner_d, src_num[owner_d][11:0]};
`else
            display_d = src_num[owner_d];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ack_q     <= '0;
            owner_q   <= '0;
            last_q    <= OW'(n_req - 1);
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            display_q <= idle_number;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            display_q <= display_d;
        end
    end

    assign grant          = grant_q;
    assign ack            = ack_q;
    assign owner          = owner_q;
    assign busy           = busy_q;
    assign display_number = display_q;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Scoreboard bench for display_share_arbiter with n_req=4, dwell_cycles=4.
// Expected outputs are queued per cycle as stimulus is applied and popped after each edge.
module tb_display_share_arbiter;
    logic        clk = 1'b0;
    logic        reset_p;
    logic [3:0]  req;
    logic [63:0] number_in;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] display_number;

    int tests_run = 0;
    int tests_failed = 0;
    int step_no = 0;

    typedef struct packed {
        logic [3:0]  grant;
        logic [3:0]  ack;
        logic [1:0]  owner;
        logic [15:0] disp;
    } exp_t;

    exp_t sb_q[$];

    display_share_arbiter #(
        .n_req(4),
        .dwell_cycles(4),
        .idle_number(16'h0000)
    ) dut (
        .clk(clk),
        .reset_p(reset_p),
        .req(req),
        .number_in(number_in),
        .grant(grant),
        .ack(ack),
        .owner(owner),
        .busy(busy),
        .display_number(display_number)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s step %0d: got %h, expected %h", tag, step_no, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk_disp(input int idx, input logic [15:0] val);
`ifdef DISPLAY_SHARE_OWNER_DIGIT_EN
        mk_disp = {4'(idx), val[11:0]};
`else
        mk_disp = val;
`endif
    endfunction

    function automatic logic [15:0] src_val(input int idx);
        logic [63:0] v;
        v = number_in;
        src_val = v[16*idx +: 16];
    endfunction

    // Queue the expectation for the next edge, advance one cycle, then pop and compare.
    task automatic step(input string name, input logic [3:0] eg, input logic [3:0] ea,
                        input logic [1:0] eo, input logic [15:0] ed);
        exp_t e;
        exp_t got;
        e.grant = eg;
        e.ack   = ea;
        e.owner = eo;
        e.disp  = ed;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        got = sb_q.pop_front();
        $display("[TB] %-10s step %0d: req=%b grant=%b ack=%b owner=%0d busy=%b disp=%h",
                 name, step_no, req, grant, ack, owner, busy, display_number);
        check_val({name, ".grant"}, 32'(grant), 32'(got.grant));
        check_val({name, ".ack"},   32'(ack),   32'(got.ack));
        check_val({name, ".owner"}, 32'(owner), 32'(got.owner));
        check_val({name, ".busy"},  32'(busy),  32'(|got.grant));
        check_val({name, ".disp"},  32'(display_number), 32'(got.disp));
    endtask

    initial begin
        reset_p   = 1'b1;
        req       = 4'b0000;
        number_in = {16'h3333, 16'h1234, 16'h1111, 16'h1000};
        step("reset", 4'b0000, 4'b0000, 2'd0, 16'h0000);
        step("reset", 4'b0000, 4'b0000, 2'd0, 16'h0000);
        reset_p = 1'b0;
        step("idle", 4'b0000, 4'b0000, 2'd0, 16'h0000);

        // Lone requester keeps the display past the dwell with no ack.
        req = 4'b0100;
        for (int c = 0; c < 7; c++)
            step("single", 4'b0100, 4'b0000, 2'd2, mk_disp(2, 16'h1234));
        req = 4'b0000;
        step("release", 4'b0000, 4'b0000, 2'd2, 16'h0000);

        // Reset restores last=3 so source 0 wins first.
        reset_p = 1'b1;
        step("reset2", 4'b0000, 4'b0000, 2'd0, 16'h0000);
        reset_p = 1'b0;

        req = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            for (int c = 0; c < 4; c++) begin
                if (g == 5 && c == 2) break;
                step("rr", 4'(1 << (g % 4)),
                     (g > 0 && c == 0) ? 4'(1 << ((g - 1) % 4)) : 4'b0000,
                     2'(g % 4), mk_disp(g % 4, src_val(g % 4)));
            end
        end

        // Owner 1 drops after two grant cycles; pending source 3 wins after one idle cycle.
        req = 4'b1000;
        step("drop", 4'b0000, 4'b0000, 2'd1, 16'h0000);
        step("pending", 4'b1000, 4'b0000, 2'd3, mk_disp(3, 16'h3333));

        number_in[63:48] = 16'h00AA;
        step("live_aa", 4'b1000, 4'b0000, 2'd3, mk_disp(3, 16'h00AA));
        number_in[63:48] = 16'h00BB;
        step("live_bb", 4'b1000, 4'b0000, 2'd3, mk_disp(3, 16'h00BB));

        reset_p = 1'b1;
        step("rst_show", 4'b0000, 4'b0000, 2'd0, 16'h0000);
        reset_p = 1'b0;
        req = 4'b0000;
        step("post_rst", 4'b0000, 4'b0000, 2'd0, 16'h0000);

        if (sb_q.size() != 0) check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
